// File: rtl/adc_sample_conditioner_if.sv
// Signal bundle between the ADC conditioning stage and its producer/consumer.
// The master side drives the ADC sample and the control levels, and the slave
// side is the conditioner itself.
interface adc_sample_conditioner_if;
    logic        [9:0]  adcData;
    logic               collectData;
    logic               testMode;
    logic               dcOffsetComp;
    logic        [15:0] dataOut;
    logic               dataValid;
    logic               clipFlag;
    logic signed [10:0] offsetOut;

    modport master (
        output adcData, collectData, testMode, dcOffsetComp,
        input  dataOut, dataValid, clipFlag, offsetOut
    );

    modport slave (
        input  adcData, collectData, testMode, dcOffsetComp,
        output dataOut, dataValid, clipFlag, offsetOut
    );
endinterface

// File: rtl/adc_sample_conditioner.sv
// Per-sample ADC conditioning stage in the ADC sampling clock domain.
// It registers the raw sample, or substitutes a test ramp in its place. It can
// remove a running-mean DC offset and clamp the result to the 10-bit range. It
// emits a 16-bit word with a write strobe while collecting, and it flags
// clipped input samples.
module adc_sample_conditioner #(
    parameter int WINDOW_LOG2 = 16,
    parameter int TEST_MAX    = 1020,
    parameter int MIDSCALE    = 512
) (
    input  logic                     inclk,
    input  logic                     reset,
    adc_sample_conditioner_if.slave  bus
);
    localparam int                 ACC_W     = 10 + WINDOW_LOG2;
    localparam logic signed [10:0] MID_S     = 11'(MIDSCALE);
    localparam logic        [9:0]  RAMP_LAST = 10'(TEST_MAX);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    // Saturate a signed compensated value to the unsigned 10-bit code range.
    function automatic logic [9:0] clamp10(input logic signed [11:0] v);
        if (v < 0)
            return 10'd0;
        else if (v > 12'sd1023)
            return 10'd1023;
        else
            return v[9:0];
    endfunction

    logic [1:0]         r_cd_sync, r_tm_sync, r_dc_sync;
    logic               w_cd_s, w_tm_s, w_dc_s;
    state_t             r_state, w_state_nxt;
    logic               w_enter;
    logic [9:0]         r_ramp;
    logic [9:0]         r_s1_p1;
    logic               r_tm_p1, r_vld_p1, r_have_p1;
    logic [ACC_W-1:0]   r_acc, w_acc_sum;
    logic [WINDOW_LOG2-1:0] r_win_cnt;
    logic               w_win_end, w_acc_en;
    logic signed [10:0] r_offset, w_new_off;
    logic signed [11:0] w_diff;
    logic [9:0]         w_comp;
    logic [9:0]         r_data_p2;
    logic               r_vld_p2;
    logic               r_clip;

    assign w_cd_s = r_cd_sync[1];
    assign w_tm_s = r_tm_sync[1];
    assign w_dc_s = r_dc_sync[1];

    // Two-flop synchronizers for the control levels arriving from the FX3 domain.
    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            r_cd_sync <= 2'b00;
            r_tm_sync <= 2'b00;
            r_dc_sync <= 2'b00;
        end else begin
            r_cd_sync <= {r_cd_sync[0], bus.collectData};
            r_tm_sync <= {r_tm_sync[0], bus.testMode};
            r_dc_sync <= {r_dc_sync[0], bus.dcOffsetComp};
        end
    end

    // Collection state register.
    always_ff @(posedge inclk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next collection state follows the synchronized collect level.
    always_comb begin
        w_state_nxt = r_state;
        w_enter     = 1'b0;
        case (r_state)
            ST_IDLE: if (w_cd_s) begin
                w_state_nxt = ST_RUN;
                w_enter     = 1'b1;
            end
            ST_RUN:  if (!w_cd_s) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Test ramp is parked at 0 outside RUN, so each RUN entry restarts it from 0.
    always_ff @(posedge inclk or posedge reset) begin
        if (reset)
            r_ramp <= 10'd0;
        else if (r_state != ST_RUN)
            r_ramp <= 10'd0;
        else if (r_ramp == RAMP_LAST)
            r_ramp <= 10'd0;
        else
            r_ramp <= r_ramp + 10'd1;
    end

    // ---- stage 1: capture the raw sample (or the ramp) with its tags ----
    // Stage 1 register; the tags keep test samples out of the DC mean and the clip check.
    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            r_s1_p1   <= 10'd0;
            r_tm_p1   <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_have_p1 <= 1'b0;
        end else begin
            r_s1_p1   <= w_tm_s ? r_ramp : bus.adcData;
            r_tm_p1   <= w_tm_s;
            r_vld_p1  <= (r_state == ST_RUN);
            r_have_p1 <= 1'b1;
        end
    end

    // The window mean is the top 10 bits of the window sum, which includes this last sample.
    assign w_acc_sum = r_acc + {{WINDOW_LOG2{1'b0}}, r_s1_p1};
    assign w_win_end = (r_win_cnt == {WINDOW_LOG2{1'b1}});
    assign w_acc_en  = r_have_p1 && !r_tm_p1;
    assign w_new_off = $signed({1'b0, w_acc_sum[ACC_W-1:WINDOW_LOG2]}) - MID_S;

    // Running-mean accumulator; test-mode samples freeze it and keep the partial sum.
    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            r_acc     <= '0;
            r_win_cnt <= '0;
            r_offset  <= 11'sd0;
        end else if (w_acc_en) begin
            if (w_win_end) begin
                r_acc     <= '0;
                r_win_cnt <= '0;
                r_offset  <= w_new_off;
            end else begin
                r_acc     <= w_acc_sum;
                r_win_cnt <= r_win_cnt + 1'b1;
            end
        end
    end

    assign w_diff = $signed({2'b00, r_s1_p1}) - $signed({r_offset[10], r_offset});
    assign w_comp = (r_tm_p1 || !w_dc_s) ? r_s1_p1 : clamp10(w_diff);

    // ---- stage 2: compensated output word and write strobe ----
    // Output register; a sample still in flight when RUN is left is dropped.
    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            r_data_p2 <= 10'd0;
            r_vld_p2  <= 1'b0;
        end else begin
            r_vld_p2 <= r_vld_p1 && (w_state_nxt == ST_RUN);
            if (r_vld_p1 && (w_state_nxt == ST_RUN))
                r_data_p2 <= w_comp;
        end
    end

    // Sticky clip flag for raw full-scale samples, re-armed on each RUN entry.
    always_ff @(posedge inclk or posedge reset) begin
        if (reset)
            r_clip <= 1'b0;
        else if (w_enter)
            r_clip <= 1'b0;
        else if ((r_state == ST_RUN) && r_vld_p1 && !r_tm_p1 &&
                 ((r_s1_p1 == 10'd0) || (r_s1_p1 == 10'd1023)))
            r_clip <= 1'b1;
    end

    assign bus.dataOut   = {6'b000000, r_data_p2};
    assign bus.dataValid = r_vld_p2;
    assign bus.clipFlag  = r_clip;
    assign bus.offsetOut = r_offset;
endmodule

// File: tb/tb_adc_sample_conditioner.sv
// Bench for adc_sample_conditioner with a 16-sample DC window.
module tb_adc_sample_conditioner;
    localparam int W    = 4;
    localparam int WIN  = 1 << W;
    localparam int TMAX = 1020;

    logic inclk = 1'b0;
    logic reset;
    adc_sample_conditioner_if bus();

    adc_sample_conditioner #(.WINDOW_LOG2(W), .TEST_MAX(TMAX), .MIDSCALE(512)) dut (
        .inclk (inclk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 inclk = ~inclk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: synchronizer delay line, run flag, one sample in flight,
    // ramp position and the list of samples in the current DC window.
    bit m_cd_mid, m_tm_mid, m_dc_mid, m_cds, m_tms, m_dcs;
    bit m_run, m_valid, m_clip;
    bit m_s1_test, m_s1_inrun, m_s1_have;
    int m_ramp, m_s1, m_out;
    int m_win[$];
    logic signed [10:0] m_off;

    function automatic int clamp_code(input int v);
        if (v < 0) return 0;
        if (v > 1023) return 1023;
        return v;
    endfunction

    always @(posedge inclk or posedge reset) begin
        if (reset) begin
            {m_cd_mid, m_tm_mid, m_dc_mid, m_cds, m_tms, m_dcs} = '0;
            {m_run, m_valid, m_clip, m_s1_test, m_s1_inrun, m_s1_have} = '0;
            m_ramp = 0; m_s1 = 0; m_out = 0; m_off = '0;
            m_win.delete();
        end else begin : model_step
            bit run_nxt, enter;
            int sum;
            run_nxt = m_cds;
            enter   = !m_run && run_nxt;
            if (m_s1_inrun && run_nxt) begin
                m_valid = 1'b1;
                m_out   = (m_s1_test || !m_dcs) ? m_s1 : clamp_code(m_s1 - int'(m_off));
            end else begin
                m_valid = 1'b0;
            end
            if (enter)
                m_clip = 1'b0;
            else if (m_run && m_s1_inrun && !m_s1_test && (m_s1 == 0 || m_s1 == 1023))
                m_clip = 1'b1;
            if (m_s1_have && !m_s1_test) begin
                m_win.push_back(m_s1);
                if (m_win.size() == WIN) begin
                    sum = 0;
                    foreach (m_win[i]) sum += m_win[i];
                    m_off = 11'(sum / WIN - 512);
                    m_win.delete();
                end
            end
            m_s1       = m_tms ? m_ramp : int'(bus.adcData);
            m_s1_test  = m_tms;
            m_s1_inrun = m_run;
            m_s1_have  = 1'b1;
            if (!m_run || m_ramp == TMAX) m_ramp = 0;
            else m_ramp = m_ramp + 1;
            m_cds = m_cd_mid; m_tms = m_tm_mid; m_dcs = m_dc_mid;
            m_cd_mid = bus.collectData; m_tm_mid = bus.testMode; m_dc_mid = bus.dcOffsetComp;
            m_run = run_nxt;
        end
    end

    task automatic test_reset;
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge inclk);
            bus.adcData = 10'($urandom_range(0, 1023));
            bus.collectData = 1'($urandom); bus.testMode = 1'($urandom); bus.dcOffsetComp = 1'($urandom);
            n_cmp++;
            if ({bus.dataOut, bus.dataValid, bus.clipFlag, bus.offsetOut} !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs c=%0d: got d=%0d v=%b c=%b o=%0d, want all 0",
                         c, bus.dataOut, bus.dataValid, bus.clipFlag, bus.offsetOut);
            end
        end
        @(negedge inclk);
        bus.collectData = 1'b0; bus.testMode = 1'b0; bus.dcOffsetComp = 1'b0;
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge inclk);
            bus.adcData = 10'($urandom_range(1, 1022));
            n_cmp++;
            if (bus.dataValid !== 1'b0 || bus.dataValid !== m_valid) begin
                n_bad++;
                $display("FAIL idle_valid c=%0d: got %b want 0", c, bus.dataValid);
            end
        end
    endtask

    task automatic test_latency;
        int drv[0:31];
        int rise = 0;
        int fell = 0;
        @(negedge inclk);
        bus.collectData = 1'b1; bus.adcData = 10'd100; drv[1] = 100;
        for (int c = 1; c <= 20; c++) begin
            @(negedge inclk);
            n_cmp++;
            if (bus.dataValid !== m_valid || (m_valid && bus.dataOut !== 16'(m_out)) ||
                bus.clipFlag !== m_clip || bus.offsetOut !== m_off) begin
                n_bad++;
                $display("FAIL model_latency c=%0d: got v=%b d=%0d c=%b o=%0d want v=%b d=%0d c=%b o=%0d",
                         c, bus.dataValid, bus.dataOut, bus.clipFlag, bus.offsetOut, m_valid, m_out, m_clip, m_off);
            end
            if (bus.dataValid === 1'b1) begin
                if (rise == 0) rise = c;
                n_cmp++;
                if (bus.dataOut !== 16'(drv[c-1])) begin
                    n_bad++;
                    $display("FAIL latency_data c=%0d: got %0d want %0d", c, bus.dataOut, drv[c-1]);
                end
            end
            bus.adcData = 10'(100 + c); drv[c+1] = 100 + c;
        end
        n_cmp++;
        if (rise != 5) begin
            n_bad++;
            $display("FAIL latency_rise: got cycle %0d want 5", rise);
        end
        bus.collectData = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge inclk);
            if (fell == 0 && bus.dataValid === 1'b0) fell = c;
        end
        n_cmp++;
        if (fell == 0) begin
            n_bad++;
            $display("FAIL latency_drop: got valid still 1 after 3 cycles want 0");
        end
        for (int c = 0; c < 6; c++) @(negedge inclk);
    endtask

    task automatic test_ramp;
        logic [15:0] q[$];
        int bad = 0;
        int first_bad = -1;
        bus.testMode = 1'b1; bus.adcData = 10'd1023; bus.collectData = 1'b1;
        for (int c = 0; c < 1100 && q.size() < 1030; c++) begin
            @(negedge inclk);
            n_cmp++;
            if (bus.dataValid !== m_valid || (m_valid && bus.dataOut !== 16'(m_out)) ||
                bus.clipFlag !== m_clip || bus.offsetOut !== m_off) begin
                n_bad++;
                $display("FAIL model_ramp c=%0d: got v=%b d=%0d c=%b o=%0d want v=%b d=%0d c=%b o=%0d",
                         c, bus.dataValid, bus.dataOut, bus.clipFlag, bus.offsetOut, m_valid, m_out, m_clip, m_off);
            end
            if (bus.dataValid === 1'b1) q.push_back(bus.dataOut);
        end
        n_cmp++;
        if (q.size() != 1030) begin
            n_bad++;
            $display("FAIL ramp_count: got %0d words want 1030", q.size());
        end
        foreach (q[k]) begin
            if (q[k] !== 16'(k % (TMAX + 1))) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL ramp_seq: word %0d got %0d want %0d (%0d wrong)",
                     first_bad, q[first_bad], first_bad % (TMAX + 1), bad);
        end
        n_cmp++;
        if (bus.clipFlag !== 1'b0) begin
            n_bad++;
            $display("FAIL ramp_clip: got %b want 0", bus.clipFlag);
        end
        bus.collectData = 1'b0; bus.testMode = 1'b0;
        for (int c = 0; c < 6; c++) @(negedge inclk);
    endtask

    task automatic test_dc;
        int first = -1;
        int last = -1;
        @(negedge inclk);
        reset = 1'b1;
        bus.adcData = 10'd600; bus.dcOffsetComp = 1'b1; bus.testMode = 1'b0; bus.collectData = 1'b1;
        @(negedge inclk);
        n_cmp++;
        if (bus.offsetOut !== 11'sd0) begin
            n_bad++;
            $display("FAIL dc_reset_offset: got %0d want 0", bus.offsetOut);
        end
        reset = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge inclk);
            n_cmp++;
            if (bus.dataValid !== m_valid || (m_valid && bus.dataOut !== 16'(m_out)) ||
                bus.clipFlag !== m_clip || bus.offsetOut !== m_off) begin
                n_bad++;
                $display("FAIL model_dc c=%0d: got v=%b d=%0d c=%b o=%0d want v=%b d=%0d c=%b o=%0d",
                         c, bus.dataValid, bus.dataOut, bus.clipFlag, bus.offsetOut, m_valid, m_out, m_clip, m_off);
            end
            if (bus.dataValid === 1'b1) begin
                if (first < 0) first = int'(bus.dataOut);
                last = int'(bus.dataOut);
            end
        end
        n_cmp++;
        if (first != 600) begin n_bad++; $display("FAIL dc_first: got %0d want 600", first); end
        n_cmp++;
        if (bus.offsetOut !== 11'sd88) begin n_bad++; $display("FAIL dc_offset: got %0d want 88", bus.offsetOut); end
        n_cmp++;
        if (last != 512) begin n_bad++; $display("FAIL dc_comp: got %0d want 512", last); end
        bus.dcOffsetComp = 1'b0;
        for (int c = 0; c < 6; c++) @(negedge inclk);
        n_cmp++;
        if (bus.dataValid !== 1'b1 || bus.dataOut !== 16'd600 || bus.offsetOut !== 11'sd88) begin
            n_bad++;
            $display("FAIL dc_bypass: got v=%b d=%0d o=%0d want v=1 d=600 o=88",
                     bus.dataValid, bus.dataOut, bus.offsetOut);
        end
    endtask

    task automatic test_clamp;
        bus.dcOffsetComp = 1'b1;
        for (int c = 0; c < 4; c++) @(negedge inclk);
        bus.adcData = 10'd50;
        @(negedge inclk);
        bus.adcData = 10'd600;
        @(negedge inclk);
        n_cmp++;
        if (bus.dataValid !== 1'b1 || bus.dataOut !== 16'd0 || bus.dataOut !== 16'(m_out)) begin
            n_bad++;
            $display("FAIL clamp_low: got v=%b d=%0d want v=1 d=0", bus.dataValid, bus.dataOut);
        end
        bus.adcData = 10'd112;
        for (int c = 0; c < 48; c++) begin
            @(negedge inclk);
            n_cmp++;
            if (bus.dataValid !== m_valid || (m_valid && bus.dataOut !== 16'(m_out)) ||
                bus.clipFlag !== m_clip || bus.offsetOut !== m_off) begin
                n_bad++;
                $display("FAIL model_clamp c=%0d: got v=%b d=%0d c=%b o=%0d want v=%b d=%0d c=%b o=%0d",
                         c, bus.dataValid, bus.dataOut, bus.clipFlag, bus.offsetOut, m_valid, m_out, m_clip, m_off);
            end
        end
        n_cmp++;
        if (bus.offsetOut !== -11'sd400) begin n_bad++; $display("FAIL clamp_offset: got %0d want -400", bus.offsetOut); end
        bus.adcData = 10'd900;
        @(negedge inclk);
        bus.adcData = 10'd112;
        @(negedge inclk);
        n_cmp++;
        if (bus.dataValid !== 1'b1 || bus.dataOut !== 16'd1023) begin
            n_bad++;
            $display("FAIL clamp_high: got v=%b d=%0d want v=1 d=1023", bus.dataValid, bus.dataOut);
        end
    endtask

    task automatic test_clip;
        bus.adcData = 10'd300;
        for (int c = 0; c < 3; c++) @(negedge inclk);
        n_cmp++;
        if (bus.clipFlag !== 1'b0) begin n_bad++; $display("FAIL clip_clear: got %b want 0", bus.clipFlag); end
        bus.adcData = 10'd0;
        @(negedge inclk);
        bus.adcData = 10'd300;
        for (int c = 0; c < 4; c++) @(negedge inclk);
        n_cmp++;
        if (bus.clipFlag !== 1'b1) begin n_bad++; $display("FAIL clip_set: got %b want 1", bus.clipFlag); end
        for (int c = 0; c < 10; c++) @(negedge inclk);
        n_cmp++;
        if (bus.clipFlag !== 1'b1) begin n_bad++; $display("FAIL clip_sticky: got %b want 1", bus.clipFlag); end
        bus.collectData = 1'b0;
        for (int c = 0; c < 6; c++) @(negedge inclk);
        n_cmp++;
        if (bus.clipFlag !== 1'b1) begin n_bad++; $display("FAIL clip_idle: got %b want 1", bus.clipFlag); end
        bus.collectData = 1'b1;
        for (int c = 0; c < 6; c++) @(negedge inclk);
        n_cmp++;
        if (bus.clipFlag !== 1'b0 || bus.clipFlag !== m_clip) begin
            n_bad++;
            $display("FAIL clip_rearm: got %b want 0", bus.clipFlag);
        end
    endtask

    task automatic test_random;
        for (int c = 0; c < 400; c++) begin
            @(negedge inclk);
            n_cmp++;
            if (bus.dataValid !== m_valid || (m_valid && bus.dataOut !== 16'(m_out)) ||
                bus.clipFlag !== m_clip || bus.offsetOut !== m_off) begin
                n_bad++;
                $display("FAIL model_random c=%0d: got v=%b d=%0d c=%b o=%0d want v=%b d=%0d c=%b o=%0d",
                         c, bus.dataValid, bus.dataOut, bus.clipFlag, bus.offsetOut, m_valid, m_out, m_clip, m_off);
            end
            bus.adcData = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 15) == 0) bus.dcOffsetComp = ~bus.dcOffsetComp;
            if ($urandom_range(0, 31) == 0) bus.collectData = ~bus.collectData;
        end
    endtask

    task automatic test_async_reset;
        bus.collectData = 1'b1; bus.adcData = 10'd400;
        for (int c = 0; c < 8; c++) @(negedge inclk);
        n_cmp++;
        if (bus.dataValid !== 1'b1) begin n_bad++; $display("FAIL areset_pre: got %b want 1", bus.dataValid); end
        @(posedge inclk);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.dataValid !== 1'b0 || bus.offsetOut !== 11'sd0 || bus.dataOut !== 16'd0) begin
            n_bad++;
            $display("FAIL areset_drop: got v=%b d=%0d o=%0d want all 0", bus.dataValid, bus.dataOut, bus.offsetOut);
        end
        @(negedge inclk);
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge inclk);
            n_cmp++;
            if (bus.dataValid !== m_valid || (m_valid && bus.dataOut !== 16'(m_out)) ||
                bus.clipFlag !== m_clip || bus.offsetOut !== m_off) begin
                n_bad++;
                $display("FAIL model_areset c=%0d: got v=%b d=%0d c=%b o=%0d want v=%b d=%0d c=%b o=%0d",
                         c, bus.dataValid, bus.dataOut, bus.clipFlag, bus.offsetOut, m_valid, m_out, m_clip, m_off);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.adcData = 10'd0; bus.collectData = 1'b0; bus.testMode = 1'b0; bus.dcOffsetComp = 1'b0;
        test_reset();
        test_latency();
        test_ramp();
        test_dc();
        test_clamp();
        test_clip();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
